// File: rtl/alarm_sequencer.sv
// Alarm sequencer: synchronises and debounces the priority encoder code, latches the active
// alarm with preemption, drives buzzer/blinking LED until acknowledged, counts alarm events.
module alarm_sequencer #(
  parameter int DEBOUNCE_CYC = 4,
  parameter int BLINK_HALF   = 8,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       in_code,
  input  logic             in_ack,
  output logic             out_active,
  output logic [1:0]       out_chan,
  output logic             out_buzzer,
  output logic             out_led,
  output logic             out_acked,
  output logic [CNT_W-1:0] out_event_cnt
);

  localparam int DBW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int BLW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYC - 1);
  localparam logic [BLW-1:0] BL_LAST = BLW'(BLINK_HALF - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ALARM = 2'd1,
    S_ACKED = 2'd2
  } state_t;

  logic [2:0]       code_s1_q, code_s2_q;
  logic             ack_s1_q, ack_s2_q, ack_s3_q;
  logic [2:0]       cand_q, cand_d;
  logic [DBW-1:0]   db_cnt_q, db_cnt_d;
  logic [2:0]       acc_q, acc_d;
  state_t           state_q, state_d;
  logic [1:0]       chan_q, chan_d;
  logic [BLW-1:0]   blink_q, blink_d;
  logic             led_q, led_d;
  logic             active_q, active_d;
  logic             buzzer_q, buzzer_d;
  logic             acked_q, acked_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic ack_rise;
  logic higher;
  logic enter;

  always_comb begin
    cand_d   = cand_q;
    db_cnt_d = db_cnt_q;
    acc_d    = acc_q;
    // Any change restarts the stability window; acceptance repeats harmlessly while stable.
    if (code_s2_q != cand_q) begin
      cand_d   = code_s2_q;
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_LAST) begin
      acc_d = cand_q;
    end else begin
      db_cnt_d = db_cnt_q + 1'b1;
    end
  end

  always_comb begin
    ack_rise = ack_s2_q & ~ack_s3_q;
    higher   = acc_q[2] && (acc_q[1:0] > chan_q);
    enter    = 1'b0;
    state_d  = state_q;
    chan_d   = chan_q;

    unique case (state_q)
      S_IDLE: begin
        if (acc_q[2]) begin
          state_d = S_ALARM;
          chan_d  = acc_q[1:0];
          enter   = 1'b1;
        end
      end
      S_ALARM: begin
        // Preemption outranks acknowledge: an ack landing on a preempt edge is dropped.
        if (!acc_q[2]) begin
          state_d = S_IDLE;
        end else if (higher) begin
          chan_d = acc_q[1:0];
          enter  = 1'b1;
        end else if (ack_rise) begin
          state_d = S_ACKED;
        end
      end
      S_ACKED: begin
        if (!acc_q[2]) begin
          state_d = S_IDLE;
        end else if (higher) begin
          state_d = S_ALARM;
          chan_d  = acc_q[1:0];
          enter   = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (state_d == S_IDLE) begin
      chan_d = '0;
    end

    blink_d = '0;
    led_d   = 1'b0;
    if (enter) begin
      led_d = 1'b1;
    end else if (state_d == S_ALARM) begin
      if (blink_q == BL_LAST) begin
        led_d = ~led_q;
      end else begin
        blink_d = blink_q + 1'b1;
        led_d   = led_q;
      end
    end else begin
      led_d = (state_d == S_ACKED);
    end

    cnt_d = cnt_q;
    if (enter && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end

    active_d = (state_d != S_IDLE);
    buzzer_d = (state_d == S_ALARM);
    acked_d  = (state_d == S_ACKED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_s1_q <= '0;
      code_s2_q <= '0;
      ack_s1_q  <= 1'b0;
      ack_s2_q  <= 1'b0;
      ack_s3_q  <= 1'b0;
      cand_q    <= '0;
      db_cnt_q  <= '0;
      acc_q     <= '0;
      state_q   <= S_IDLE;
      chan_q    <= '0;
      blink_q   <= '0;
      led_q     <= 1'b0;
      active_q  <= 1'b0;
      buzzer_q  <= 1'b0;
      acked_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      code_s1_q <= in_code;
      code_s2_q <= code_s1_q;
      ack_s1_q  <= in_ack;
      ack_s2_q  <= ack_s1_q;
      ack_s3_q  <= ack_s2_q;
      cand_q    <= cand_d;
      db_cnt_q  <= db_cnt_d;
      acc_q     <= acc_d;
      state_q   <= state_d;
      chan_q    <= chan_d;
      blink_q   <= blink_d;
      led_q     <= led_d;
      active_q  <= active_d;
      buzzer_q  <= buzzer_d;
      acked_q   <= acked_d;
      cnt_q     <= cnt_d;
    end
  end

  assign out_active    = active_q;
  assign out_chan      = chan_q;
  assign out_buzzer    = buzzer_q;
  assign out_led       = led_q;
  assign out_acked     = acked_q;
  assign out_event_cnt = cnt_q;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Bench for alarm_sequencer: timed vector table with an expected-value queue, reset and
// saturation sequences on a second instance with a 2-bit event counter.
module tb_alarm_sequencer;

  logic       clk;
  logic       rst_n;
  logic [2:0] in_code;
  logic       in_ack;
  logic       out_active;
  logic [1:0] out_chan;
  logic       out_buzzer;
  logic       out_led;
  logic       out_acked;
  logic [7:0] out_event_cnt;

  logic [2:0] in_code2;
  logic       in_ack2;
  logic       out_active2;
  logic [1:0] out_chan2;
  logic       out_buzzer2;
  logic       out_led2;
  logic       out_acked2;
  logic [1:0] out_event_cnt2;

  int n_checks = 0;
  int n_pass   = 0;

  logic [13:0] exp_q[$];

  typedef struct {
    string      name;
    logic [2:0] code;
    logic       ack;
    int         cycles;
    logic       active;
    logic [1:0] chan;
    logic       buzzer;
    logic       led;
    logic       acked;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs[$];

  alarm_sequencer #(.DEBOUNCE_CYC(4), .BLINK_HALF(8), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_code(in_code), .in_ack(in_ack),
    .out_active(out_active), .out_chan(out_chan), .out_buzzer(out_buzzer),
    .out_led(out_led), .out_acked(out_acked), .out_event_cnt(out_event_cnt)
  );

  alarm_sequencer #(.DEBOUNCE_CYC(4), .BLINK_HALF(8), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_code(in_code2), .in_ack(in_ack2),
    .out_active(out_active2), .out_chan(out_chan2), .out_buzzer(out_buzzer2),
    .out_led(out_led2), .out_acked(out_acked2), .out_event_cnt(out_event_cnt2)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "timeout");
  end

  function automatic logic [13:0] pack(input logic a, input logic [1:0] ch, input logic bz,
                                       input logic ld, input logic ak, input logic [7:0] c);
    return {a, ch, bz, ld, ak, c};
  endfunction

  function automatic logic [13:0] dut_out();
    return pack(out_active, out_chan, out_buzzer, out_led, out_acked, out_event_cnt);
  endfunction

  function automatic logic [13:0] dut2_out();
    return pack(out_active2, out_chan2, out_buzzer2, out_led2, out_acked2, {6'd0, out_event_cnt2});
  endfunction

  task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got act=%b ch=%0d bz=%b led=%b ack=%b cnt=%0d, want act=%b ch=%0d bz=%b led=%b ack=%b cnt=%0d",
               name, act[13], act[12:11], act[10], act[9], act[8], act[7:0],
               exp[13], exp[12:11], exp[10], exp[9], exp[8], exp[7:0]);
    end
  endtask

  task automatic add_vec(input string name, input logic [2:0] code, input logic ack, input int cycles,
                         input logic a, input logic [1:0] ch, input logic bz, input logic ld,
                         input logic ak, input logic [7:0] c);
    vec_t v;
    v.name = name; v.code = code; v.ack = ack; v.cycles = cycles;
    v.active = a; v.chan = ch; v.buzzer = bz; v.led = ld; v.acked = ak; v.cnt = c;
    vecs.push_back(v);
  endtask

  // driver: inputs change on the falling edge; an ack is a single-cycle pulse
  task automatic apply(input vec_t v);
    logic [13:0] exp;
    @(negedge clk);
    in_code = v.code;
    in_ack  = v.ack;
    exp_q.push_back(pack(v.active, v.chan, v.buzzer, v.led, v.acked, v.cnt));
    for (int k = 0; k < v.cycles; k++) begin
      @(posedge clk);
      if (k == 0 && v.cycles > 1) begin
        @(negedge clk);
        in_ack = 1'b0;
      end
    end
    #1;
    exp = exp_q.pop_front();
    check(v.name, dut_out(), exp);
  endtask

  task automatic apply2(input string name, input logic [2:0] code, input int cycles,
                        input logic [13:0] exp_in);
    logic [13:0] exp;
    @(negedge clk);
    in_code2 = code;
    exp_q.push_back(exp_in);
    repeat (cycles) @(posedge clk);
    #1;
    exp = exp_q.pop_front();
    check(name, dut2_out(), exp);
  endtask

  initial begin
    //        name            code    ack cyc  act ch bz led ak cnt
    add_vec("pre_accept",     3'b101, 0, 7,   0, 0, 0, 0, 0, 0);
    add_vec("accept_edge8",   3'b101, 0, 1,   1, 1, 1, 1, 0, 1);
    add_vec("led_hi_end",     3'b101, 0, 7,   1, 1, 1, 1, 0, 1);
    add_vec("led_toggle_lo",  3'b101, 0, 1,   1, 1, 1, 0, 0, 1);
    add_vec("led_lo_end",     3'b101, 0, 7,   1, 1, 1, 0, 0, 1);
    add_vec("led_toggle_hi",  3'b101, 0, 1,   1, 1, 1, 1, 0, 1);
    add_vec("pre_preempt",    3'b111, 0, 7,   1, 1, 1, 1, 0, 1);
    add_vec("preempt",        3'b111, 0, 1,   1, 3, 1, 1, 0, 2);
    add_vec("lower_code",     3'b100, 0, 8,   1, 3, 1, 0, 0, 2);
    add_vec("ack_pre",        3'b100, 1, 2,   1, 3, 1, 0, 0, 2);
    add_vec("ack_3rd_edge",   3'b100, 0, 1,   1, 3, 0, 1, 1, 2);
    add_vec("acked_hold",     3'b000, 0, 7,   1, 3, 0, 1, 1, 2);
    add_vec("acked_clear",    3'b000, 0, 1,   0, 0, 0, 0, 0, 2);
    add_vec("glitch_on",      3'b111, 0, 3,   0, 0, 0, 0, 0, 2);
    add_vec("glitch_reject",  3'b000, 0, 10,  0, 0, 0, 0, 0, 2);
    add_vec("alarm_ch2",      3'b110, 0, 8,   1, 2, 1, 1, 0, 3);
    add_vec("unacked_clear",  3'b000, 0, 8,   0, 0, 0, 0, 0, 3);
    add_vec("alarm_ch0",      3'b100, 0, 8,   1, 0, 1, 1, 0, 4);
    add_vec("ack_ch0",        3'b100, 1, 3,   1, 0, 0, 1, 1, 4);
    add_vec("acked_to_alarm", 3'b101, 0, 8,   1, 1, 1, 1, 0, 5);
    add_vec("clear_again",    3'b000, 0, 8,   0, 0, 0, 0, 0, 5);
    add_vec("ack_in_idle",    3'b000, 1, 4,   0, 0, 0, 0, 0, 5);
    add_vec("alarm_ch1_b",    3'b101, 0, 8,   1, 1, 1, 1, 0, 6);
    add_vec("pre_collide",    3'b111, 0, 5,   1, 1, 1, 1, 0, 6);
    add_vec("ack_vs_preempt", 3'b111, 1, 3,   1, 3, 1, 1, 0, 7);
    add_vec("ack_dropped",    3'b111, 0, 4,   1, 3, 1, 1, 0, 7);

    in_code  = 3'b000;
    in_ack   = 1'b0;
    in_code2 = 3'b000;
    in_ack2  = 1'b0;
    rst_n    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", dut_out(), pack(0, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) apply(vecs[i]);

    // asynchronous reset mid-alarm, checked before any clock edge
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset", dut_out(), pack(0, 0, 0, 0, 0, 0));
    in_code = 3'b000;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("post_reset_idle", dut_out(), pack(0, 0, 0, 0, 0, 0));

    // 2-bit event counter saturates at 3
    for (int i = 0; i < 5; i++) begin
      logic [7:0] c;
      c = (i + 1 > 3) ? 8'd3 : 8'(i + 1);
      apply2("sat_alarm", 3'b110, 8, pack(1, 2, 1, 1, 0, c));
      apply2("sat_clear", 3'b000, 8, pack(0, 0, 0, 0, 0, c));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
